// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Definitions shared by the multicycle RV32I control FSM, the ALU decoder and
// the datapath muxes: the 4-bit state encoding, the major opcodes, and the
// select/ALUOp encodings.
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_JALR_ADR = 4'd9,
      S_JAL      = 4'd10,
      S_BRANCH   = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Only beq (000) and bne (001) are implemented.
   function automatic logic is_supported_branch(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b001);
   endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// ---------------------------------------------------------------------------
// multicycle_next_state
// Purely combinational next-state and illegal-instruction detection for the
// multicycle control FSM.
// Ports:
//   state      : current state (4-bit encoding of state_t)
//   opcode     : instr[6:0]
//   funct3     : instr[14:12]
//   mem_ready  : memory access complete this cycle
//   next_state : state to load on the next clock edge
//   illegal    : DECODE sees an unsupported opcode / branch funct3
// ---------------------------------------------------------------------------
module multicycle_next_state
   import rv_ctrl_pkg::*;
(
   input  logic [3:0] state,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       mem_ready,
   output logic [3:0] next_state,
   output logic       illegal
);

   always_comb begin
      next_state = S_FETCH;
      illegal    = 1'b0;
      case (state)
         S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_R:              next_state = S_EXECUTER;
               OP_I:              next_state = S_EXECUTEI;
               OP_JAL:            next_state = S_JAL;
               OP_JALR:           next_state = S_JALR_ADR;
               OP_BRANCH: begin
                  if (is_supported_branch(funct3)) next_state = S_BRANCH;
                  else                             illegal    = 1'b1;
               end
               default:           illegal    = 1'b1;
            endcase
         end
         // opcode[5] separates store (0100011) from load (0000011).
         S_MEMADR:   next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  next_state = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    next_state = S_FETCH;
         S_MEMWRITE: next_state = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: next_state = S_ALUWB;
         S_EXECUTEI: next_state = S_ALUWB;
         S_ALUWB:    next_state = S_FETCH;
         S_JALR_ADR: next_state = S_JAL;
         S_JAL:      next_state = S_ALUWB;
         S_BRANCH:   next_state = S_FETCH;
         default:    next_state = S_FETCH;   // unused encodings recover
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Main control FSM for the multicycle RV32I datapath. Holds the state
// register and retired-instruction counter, and decodes datapath enables,
// mux selects and ALUOp from the current state.
//
// Memory handshake: the FSM presents an access in FETCH, MEMREAD or MEMWRITE
// and keeps every output of that state stable until it samples mem_ready=1 on
// a rising clk edge; that edge completes the access and leaves the state.
// mem_ready is ignored in all other states.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   opcode, funct3    : fields from the instruction register
//   Zero              : ALU zero flag (branch resolution)
//   mem_ready         : unified memory completed the current access
//   PCWrite..RegWrite : datapath enables / selects / ALUOp
//   illegal_instr     : one-cycle pulse in DECODE for unsupported encodings
//   instr_retired     : count of completed instructions (wraps)
//   state             : current state, for debug
// ---------------------------------------------------------------------------
module multicycle_control_fsm
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic             RegWrite,
   output logic             illegal_instr,
   output logic [CNT_W-1:0] instr_retired,
   output logic [3:0]       state
);

   state_t     state_q;
   logic [3:0] next_state;
   logic       illegal_dec;
   logic       retire;

   logic pc_update, branch, ir_write_d, reg_write_d, mem_write_d;

   multicycle_next_state u_next_state (
      .state      (state_q),
      .opcode     (opcode),
      .funct3     (funct3),
      .mem_ready  (mem_ready),
      .next_state (next_state),
      .illegal    (illegal_dec)
   );

   // Instruction completes on the edge that leaves its last state for FETCH.
   assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                   (state_q == S_BRANCH) ||
                   ((state_q == S_MEMWRITE) && mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_FETCH;
         instr_retired <= '0;
      end else begin
         state_q <= state_t'(next_state);
         if (retire) instr_retired <= instr_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Outputs are decoded from the registered state. FETCH enables and the
   // branch PCWrite also need mem_ready / Zero of the current cycle, so this
   // decode is combinational on top of the state register.
   always_comb begin
      pc_update   = 1'b0;
      branch      = 1'b0;
      ir_write_d  = 1'b0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      AdrSrc      = 1'b0;
      ResultSrc   = RES_ALUOUT;
      ALUSrcA     = SRCA_PC;
      ALUSrcB     = SRCB_RS2;
      ALUOp       = ALUOP_ADD;
      case (state_q)
         S_FETCH: begin
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALURESULT;
            ir_write_d = mem_ready;
            pc_update  = mem_ready;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMADR, S_JALR_ADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB: begin
            ResultSrc   = RES_DATA;
            reg_write_d = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc      = 1'b1;
            mem_write_d = 1'b1;
         end
         S_EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp   = ALUOP_FUNCT;
         end
         S_ALUWB:    reg_write_d = 1'b1;
         S_JAL: begin
            ALUSrcA   = SRCA_OLDPC;
            ALUSrcB   = SRCB_FOUR;
            pc_update = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RS1;
            ALUOp   = ALUOP_BRANCH;
            branch  = 1'b1;
         end
         default: ;
      endcase
   end

   // Write enables are gated by rst_n so that no write can occur while reset
   // is held, even though FETCH would otherwise react to mem_ready.
   // funct3[0] flips the sense of Zero: beq takes on Zero, bne on !Zero.
   assign PCWrite       = rst_n & (pc_update | (branch & (Zero ^ funct3[0])));
   assign IRWrite       = rst_n & ir_write_d;
   assign RegWrite      = rst_n & reg_write_d;
   assign MemWrite      = rst_n & mem_write_d;
   assign illegal_instr = rst_n & illegal_dec;
   assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
  import rv_ctrl_pkg::*;

  localparam int CNT_W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = OP_R;
  logic [2:0] funct3 = 3'b000;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [CNT_W-1:0] instr_retired;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct3        (funct3),
    .Zero          (zero),
    .mem_ready     (mem_ready),
    .PCWrite       (pc_write),
    .AdrSrc        (adr_src),
    .MemWrite      (mem_write),
    .IRWrite       (ir_write),
    .ResultSrc     (result_src),
    .ALUSrcA       (alu_src_a),
    .ALUSrcB       (alu_src_b),
    .ALUOp         (alu_op),
    .RegWrite      (reg_write),
    .illegal_instr (illegal_instr),
    .instr_retired (instr_retired),
    .state         (state)
  );

  // observed vector: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  // ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal_instr
  logic [17:0] obs_vec;
  assign obs_vec = {state, pc_write, adr_src, mem_write, ir_write, result_src,
                    alu_src_a, alu_src_b, alu_op, reg_write, illegal_instr};

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int n_pass = 0;
  int n_total = 0;

  // Reference output table written from the state descriptions.
  function automatic logic [17:0] model(input logic [3:0] st, input logic mr,
                                        input logic z, input logic [2:0] f3,
                                        input logic ill);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, op;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; op = 2'b00;
    case (st)
      4'd0:  begin sb = 2'b10; rs = 2'b10; irw = mr; pcw = mr; end    // FETCH
      4'd1:  begin sa = 2'b01; sb = 2'b01; end                        // DECODE
      4'd2:  begin sa = 2'b10; sb = 2'b01; end                        // MEMADR
      4'd3:  begin adr = 1; end                                       // MEMREAD
      4'd4:  begin rs = 2'b01; rw = 1; end                            // MEMWB
      4'd5:  begin adr = 1; mw = 1; end                               // MEMWRITE
      4'd6:  begin sa = 2'b10; sb = 2'b00; op = 2'b10; end            // EXECUTER
      4'd7:  begin sa = 2'b10; sb = 2'b01; op = 2'b10; end            // EXECUTEI
      4'd8:  begin rw = 1; end                                        // ALUWB
      4'd9:  begin sa = 2'b10; sb = 2'b01; end                        // JALR_ADR
      4'd10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end               // JAL
      4'd11: begin sa = 2'b10; op = 2'b01; pcw = (f3 == 3'b000) ? z : ~z; end // BRANCH
      default: ;
    endcase
    return {st, pcw, adr, mw, irw, rs, sa, sb, op, rw, ill};
  endfunction

  task automatic check_vec(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs for the current cycle, push expected outputs, sample #1 later.
  task automatic sample(input string tag, input logic [3:0] st, input logic mr,
                        input logic z, input logic ill);
    mem_ready = mr;
    zero = z;
    exp_q.push_back(model(st, mr, z, funct3, ill));
    #1;
    check_vec(tag, obs_vec, exp_q.pop_front());
  endtask

  // One full cycle: sample, then advance to the next negedge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic mr,
                     input logic z, input logic ill);
    sample(tag, st, mr, z, ill);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset state with mem_ready high: no enables, FETCH selects
    #2;
    sample("reset_outputs", S_FETCH, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b1;
    #1;
    check_vec("reset_no_irwrite", obs_vec, model(S_FETCH, 1'b0, 1'b0, 3'b000, 1'b0));
    check_cnt("reset_cnt", instr_retired, exp_cnt);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // add x3,x1,x2 (0x002081B3)
    set_instr(7'b0110011, 3'b000);
    cyc("add_fetch",    S_FETCH,    1, 0, 0);
    cyc("add_decode",   S_DECODE,   1, 0, 0);
    cyc("add_executer", S_EXECUTER, 1, 0, 0);
    cyc("add_aluwb",    S_ALUWB,    1, 0, 0);
    exp_cnt++;
    check_cnt("add_retired", instr_retired, exp_cnt);

    // lw with three stall cycles in MEMREAD (8 cycles total)
    set_instr(OP_LOAD, 3'b010);
    cyc("lw_fetch",    S_FETCH,   1, 0, 0);
    cyc("lw_decode",   S_DECODE,  1, 0, 0);
    cyc("lw_memadr",   S_MEMADR,  1, 0, 0);
    for (int i = 0; i < 3; i++) cyc("lw_memread_stall", S_MEMREAD, 0, 0, 0);
    cyc("lw_memread",  S_MEMREAD, 1, 0, 0);
    cyc("lw_memwb",    S_MEMWB,   1, 0, 0);
    exp_cnt++;
    check_cnt("lw_retired", instr_retired, exp_cnt);

    // sw with a fetch stall and a write stall
    set_instr(OP_STORE, 3'b010);
    cyc("sw_fetch_stall", S_FETCH,    0, 0, 0);
    cyc("sw_fetch",       S_FETCH,    1, 0, 0);
    cyc("sw_decode",      S_DECODE,   1, 0, 0);
    cyc("sw_memadr",      S_MEMADR,   1, 0, 0);
    cyc("sw_write_stall", S_MEMWRITE, 0, 0, 0);
    check_cnt("sw_stall_no_retire", instr_retired, exp_cnt);
    cyc("sw_write",       S_MEMWRITE, 1, 0, 0);
    exp_cnt++;
    check_cnt("sw_retired", instr_retired, exp_cnt);

    // bne: taken with Zero=0, not taken with Zero=1
    set_instr(OP_BRANCH, 3'b001);
    cyc("bne_fetch",  S_FETCH,  1, 0, 0);
    cyc("bne_decode", S_DECODE, 1, 0, 0);
    cyc("bne_taken",  S_BRANCH, 1, 0, 0);
    exp_cnt++;
    cyc("bne2_fetch",  S_FETCH,  1, 1, 0);
    cyc("bne2_decode", S_DECODE, 1, 1, 0);
    cyc("bne_nottaken", S_BRANCH, 1, 1, 0);
    exp_cnt++;
    // beq taken with Zero=1
    set_instr(OP_BRANCH, 3'b000);
    cyc("beq_fetch",  S_FETCH,  1, 1, 0);
    cyc("beq_decode", S_DECODE, 1, 1, 0);
    cyc("beq_taken",  S_BRANCH, 1, 1, 0);
    exp_cnt++;
    check_cnt("branch_retired", instr_retired, exp_cnt);

    // jalr
    set_instr(OP_JALR, 3'b000);
    cyc("jalr_fetch",  S_FETCH,    1, 0, 0);
    cyc("jalr_decode", S_DECODE,   1, 0, 0);
    cyc("jalr_adr",    S_JALR_ADR, 1, 0, 0);
    cyc("jalr_jal",    S_JAL,      1, 0, 0);
    cyc("jalr_aluwb",  S_ALUWB,    1, 0, 0);
    exp_cnt++;

    // jal
    set_instr(OP_JAL, 3'b000);
    cyc("jal_fetch",  S_FETCH,  1, 0, 0);
    cyc("jal_decode", S_DECODE, 1, 0, 0);
    cyc("jal_jal",    S_JAL,    1, 0, 0);
    cyc("jal_aluwb",  S_ALUWB,  1, 0, 0);
    exp_cnt++;

    // addi
    set_instr(OP_I, 3'b000);
    cyc("addi_fetch",    S_FETCH,    1, 0, 0);
    cyc("addi_decode",   S_DECODE,   1, 0, 0);
    cyc("addi_executei", S_EXECUTEI, 1, 0, 0);
    cyc("addi_aluwb",    S_ALUWB,    1, 0, 0);
    exp_cnt++;
    check_cnt("jump_imm_retired", instr_retired, exp_cnt);

    // illegal opcode 0x7F
    set_instr(7'h7F, 3'b000);
    cyc("ill_op_fetch",  S_FETCH,  1, 0, 0);
    cyc("ill_op_decode", S_DECODE, 1, 0, 1);
    check_cnt("ill_op_cnt", instr_retired, exp_cnt);
    // illegal branch funct3=100
    set_instr(OP_BRANCH, 3'b100);
    cyc("ill_br_fetch",  S_FETCH,  1, 0, 0);
    cyc("ill_br_decode", S_DECODE, 1, 0, 1);
    check_cnt("ill_br_cnt", instr_retired, exp_cnt);
    cyc("ill_br_back_fetch", S_FETCH, 0, 0, 0);

    // reset pulsed in MEMWRITE while mem_ready=1
    set_instr(OP_STORE, 3'b010);
    cyc("rst_sw_fetch",  S_FETCH,  1, 0, 0);
    cyc("rst_sw_decode", S_DECODE, 1, 0, 0);
    cyc("rst_sw_memadr", S_MEMADR, 1, 0, 0);
    sample("rst_sw_memwrite", S_MEMWRITE, 1, 0, 0);
    rst_n = 1'b0;
    exp_cnt = '0;
    #1;
    check_vec("rst_async_abort", obs_vec, model(S_FETCH, 1'b0, 1'b0, funct3, 1'b0));
    check_cnt("rst_async_cnt", instr_retired, exp_cnt);
    @(posedge clk);
    @(negedge clk);
    check_vec("rst_held", obs_vec, model(S_FETCH, 1'b0, 1'b0, funct3, 1'b0));
    rst_n = 1'b1;
    cyc("resume_fetch",  S_FETCH,  1, 0, 0);
    cyc("resume_decode", S_DECODE, 1, 0, 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
